// File: rtl/tdc_gpx_pkg.sv
// Shared TDC-GPX definitions: bus widths, register indices, arbiter
// state encoding, the captured command record and the grant helper.
package tdc_gpx_pkg;

   localparam int TDC_ADDR_W = 4;
   localparam int TDC_DATA_W = 28;

   localparam logic [TDC_ADDR_W-1:0] REG_FIFO1 = 4'd8;
   localparam logic [TDC_ADDR_W-1:0] REG_RESET = 4'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   // One command as captured from a requester and replayed downstream.
   typedef struct packed {
      logic                  read_write;
      logic [TDC_ADDR_W-1:0] addr;
      logic [TDC_DATA_W-1:0] data;
   } tdc_cmd_t;

   // Requester 0 has priority; requester 1 wins when it is the only one
   // waiting, or when it has been passed over often enough.
   function automatic logic pick_req1(input logic slot0_full,
                                      input logic slot1_full,
                                      input logic starved);
      return slot1_full && (!slot0_full || starved);
   endfunction

endpackage

// File: rtl/tdc_rw_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the
// downstream TDC-GPX read/write controller. The master side is the
// environment (requesters plus downstream controller), the slave side
// is the arbiter.
interface tdc_rw_arbiter_if;
   import tdc_gpx_pkg::*;

   // requester 0 (acquisition controller)
   logic                  req0_mem_op;
   logic                  req0_read_write;
   logic [TDC_ADDR_W-1:0] req0_addr;
   logic [TDC_DATA_W-1:0] req0_data_in;
   logic                  req0_ready;
   logic [TDC_DATA_W-1:0] req0_data_out;
   logic                  req0_data_ready;
   logic                  req0_done;

   // requester 1 (host register access)
   logic                  req1_mem_op;
   logic                  req1_read_write;
   logic [TDC_ADDR_W-1:0] req1_addr;
   logic [TDC_DATA_W-1:0] req1_data_in;
   logic                  req1_ready;
   logic [TDC_DATA_W-1:0] req1_data_out;
   logic                  req1_data_ready;
   logic                  req1_done;

   // downstream controller port
   logic                  rw_ready;
   logic [TDC_DATA_W-1:0] rw_data_out;
   logic                  rw_data_ready;
   logic                  rw_mem_op;
   logic                  rw_read_write;
   logic [TDC_ADDR_W-1:0] rw_addr;
   logic [TDC_DATA_W-1:0] rw_data_in;

   modport master (
      output req0_mem_op, req0_read_write, req0_addr, req0_data_in,
      input  req0_ready, req0_data_out, req0_data_ready, req0_done,
      output req1_mem_op, req1_read_write, req1_addr, req1_data_in,
      input  req1_ready, req1_data_out, req1_data_ready, req1_done,
      output rw_ready, rw_data_out, rw_data_ready,
      input  rw_mem_op, rw_read_write, rw_addr, rw_data_in
   );

   modport slave (
      input  req0_mem_op, req0_read_write, req0_addr, req0_data_in,
      output req0_ready, req0_data_out, req0_data_ready, req0_done,
      input  req1_mem_op, req1_read_write, req1_addr, req1_data_in,
      output req1_ready, req1_data_out, req1_data_ready, req1_done,
      input  rw_ready, rw_data_out, rw_data_ready,
      output rw_mem_op, rw_read_write, rw_addr, rw_data_in
   );

endinterface

// File: rtl/tdc_rw_req_slot.sv
// One-deep request slot: captures a strobed command, tracks whether it
// is still waiting for a grant, and keeps ready low until the granted
// transaction has completed. Flags strobes that arrive while not ready.
module tdc_rw_req_slot
   import tdc_gpx_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     mem_op,
   input  tdc_cmd_t cmd_in,
   input  logic     take,      // arbiter has copied the command out
   input  logic     complete,  // transaction of this requester finished
   output logic     valid,
   output tdc_cmd_t cmd,
   output logic     ready,
   output logic     overrun
);

   logic     valid_reg;
   logic     ready_reg;
   tdc_cmd_t cmd_reg;

   // Capture on an accepted strobe; release the slot on grant and
   // reopen the requester only once its transaction has completed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg <= 1'b0;
         ready_reg <= 1'b1;
         cmd_reg   <= '0;
      end else if (mem_op && ready_reg) begin
         valid_reg <= 1'b1;
         ready_reg <= 1'b0;
         cmd_reg   <= cmd_in;
      end else begin
         if (take) begin
            valid_reg <= 1'b0;
         end
         if (complete) begin
            ready_reg <= 1'b1;
         end
      end
   end

   assign valid   = valid_reg;
   assign cmd     = cmd_reg;
   assign ready   = ready_reg;
   assign overrun = mem_op && !ready_reg;

endmodule

// File: rtl/tdc_rw_arbiter.sv
// Two-requester arbiter for the single TDC-GPX read/write controller
// port: fixed priority to requester 0 with a starvation guard for
// requester 1, and a completion timeout so a hung cycle frees the port.
module tdc_rw_arbiter
   import tdc_gpx_pkg::*;
#(
   parameter int STARVE_LIMIT   = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset,
   tdc_rw_arbiter_if.slave bus,
   output logic            err_timeout,
   output logic            err_overrun
);

   localparam int         STARVE_W     = $clog2(STARVE_LIMIT + 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   arb_state_t          state_reg, state_next;
   logic                grant_reg, grant_next;
   logic [STARVE_W-1:0] starve_reg, starve_next;
   logic [7:0]          wait_cnt_reg, wait_cnt_next;
   logic                rw_mem_op_reg;
   tdc_cmd_t            rw_cmd_reg;
   logic                err_timeout_reg;
   logic                err_overrun_reg;

   logic [1:0]            strobe;
   logic [1:0]            slot_valid;
   logic [1:0]            slot_ready;
   logic [1:0]            slot_overrun;
   logic [1:0]            slot_take;
   logic [1:0]            slot_complete;
   logic [1:0]            req_done;
   logic [1:0]            req_data_ready;
   tdc_cmd_t              slot_cmd_in [2];
   tdc_cmd_t              slot_cmd    [2];
   logic [TDC_DATA_W-1:0] req_data_out [2];

   logic load_cmd;
   logic finish;
   logic read_ok;
   logic timed_out;

   assign strobe         = {bus.req1_mem_op, bus.req0_mem_op};
   assign slot_cmd_in[0] = {bus.req0_read_write, bus.req0_addr, bus.req0_data_in};
   assign slot_cmd_in[1] = {bus.req1_read_write, bus.req1_addr, bus.req1_data_in};

   for (genvar gi = 0; gi < 2; gi++) begin : gen_req
      logic                  mine;
      logic [TDC_DATA_W-1:0] data_out_reg;
      logic                  data_ready_reg;
      logic                  done_reg;

      assign mine              = (grant_reg == 1'(gi));
      assign slot_take[gi]     = load_cmd && (grant_next == 1'(gi));
      assign slot_complete[gi] = finish && mine;

      tdc_rw_req_slot u_slot (
         .clk      (clk),
         .reset    (reset),
         .mem_op   (strobe[gi]),
         .cmd_in   (slot_cmd_in[gi]),
         .take     (slot_take[gi]),
         .complete (slot_complete[gi]),
         .valid    (slot_valid[gi]),
         .cmd      (slot_cmd[gi]),
         .ready    (slot_ready[gi]),
         .overrun  (slot_overrun[gi])
      );

      // Completion pulses and read-data capture for this requester; an
      // aborted read leaves the previous read result untouched.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            data_out_reg   <= '0;
            data_ready_reg <= 1'b0;
            done_reg       <= 1'b0;
         end else begin
            done_reg       <= finish && mine;
            data_ready_reg <= read_ok && mine;
            if (read_ok && mine) begin
               data_out_reg <= bus.rw_data_out;
            end
         end
      end

      assign req_data_out[gi]   = data_out_reg;
      assign req_done[gi]       = done_reg;
      assign req_data_ready[gi] = data_ready_reg;
   end

   // Next-state, grant choice, starvation count and completion detection.
   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      starve_next   = starve_reg;
      wait_cnt_next = wait_cnt_reg;
      load_cmd      = 1'b0;
      finish        = 1'b0;
      read_ok       = 1'b0;
      timed_out     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.rw_ready && (slot_valid != 2'b00)) begin
               state_next = ISSUE;
               load_cmd   = 1'b1;
               if (pick_req1(slot_valid[0], slot_valid[1],
                             starve_reg >= STARVE_W'(STARVE_LIMIT))) begin
                  grant_next  = 1'b1;
                  starve_next = '0;
               end else begin
                  grant_next = 1'b0;
                  if (slot_valid[1]) begin
                     starve_next = starve_reg + STARVE_W'(1);
                  end
               end
            end
         end
         ISSUE: begin
            state_next    = WAIT;
            wait_cnt_next = '0;
         end
         WAIT: begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
            if (rw_cmd_reg.read_write) begin
               if (bus.rw_data_ready) begin
                  finish  = 1'b1;
                  read_ok = 1'b1;
               end
            end else if (bus.rw_ready && (wait_cnt_reg != 8'd0)) begin
               // the first WAIT cycle is too early: the controller may
               // not have dropped rw_ready yet after the strobe
               finish = 1'b1;
            end
            if (!finish && (wait_cnt_reg == TIMEOUT_LAST)) begin
               finish    = 1'b1;
               timed_out = 1'b1;
            end
            if (finish) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM, grant and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         grant_reg    <= 1'b0;
         starve_reg   <= '0;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         starve_reg   <= starve_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // Downstream strobe and command, held from ISSUE until the next grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rw_mem_op_reg <= 1'b0;
         rw_cmd_reg    <= '{read_write: 1'b1, addr: '0, data: '0};
      end else begin
         rw_mem_op_reg <= (state_next == ISSUE);
         if (load_cmd) begin
            rw_cmd_reg <= slot_cmd[grant_next];
         end
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_timeout_reg <= 1'b0;
         err_overrun_reg <= 1'b0;
      end else begin
         err_timeout_reg <= err_timeout_reg | timed_out;
         err_overrun_reg <= err_overrun_reg | (|slot_overrun);
      end
   end

   assign bus.rw_mem_op       = rw_mem_op_reg;
   assign bus.rw_read_write   = rw_cmd_reg.read_write;
   assign bus.rw_addr         = rw_cmd_reg.addr;
   assign bus.rw_data_in      = rw_cmd_reg.data;

   assign bus.req0_ready      = slot_ready[0];
   assign bus.req0_data_out   = req_data_out[0];
   assign bus.req0_data_ready = req_data_ready[0];
   assign bus.req0_done       = req_done[0];
   assign bus.req1_ready      = slot_ready[1];
   assign bus.req1_data_out   = req_data_out[1];
   assign bus.req1_data_ready = req_data_ready[1];
   assign bus.req1_done       = req_done[1];

   assign err_timeout = err_timeout_reg;
   assign err_overrun = err_overrun_reg;

endmodule

// File: tb/tb_tdc_rw_arbiter.sv
// Bench for tdc_rw_arbiter: table of single transactions followed by
// hand-written sequences for arbitration, starvation, timeout, overrun
// and reset.
module tb_tdc_rw_arbiter;
   import tdc_gpx_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic err_timeout;
   logic err_overrun;

   tdc_rw_arbiter_if bus ();

   tdc_rw_arbiter #(
      .STARVE_LIMIT   (8),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [27:0] last_rd [2];

   typedef struct {
      int          req;
      logic        rd;
      logic [3:0]  addr;
      logic [27:0] wdata;
      logic [27:0] rdata;
      int          lat;
      int          exp_done;
      logic [27:0] exp_dout;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int r, input logic op, input logic rd,
                            input logic [3:0] a, input logic [27:0] d);
      if (r == 0) begin
         bus.req0_mem_op = op; bus.req0_read_write = rd;
         bus.req0_addr = a; bus.req0_data_in = d;
      end else begin
         bus.req1_mem_op = op; bus.req1_read_write = rd;
         bus.req1_addr = a; bus.req1_data_in = d;
      end
   endtask

   function automatic logic rdy(input int r);
      return (r == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction
   function automatic logic done_of(input int r);
      return (r == 0) ? bus.req0_done : bus.req1_done;
   endfunction
   function automatic logic drdy_of(input int r);
      return (r == 0) ? bus.req0_data_ready : bus.req1_data_ready;
   endfunction
   function automatic logic [27:0] dout_of(input int r);
      return (r == 0) ? bus.req0_data_out : bus.req1_data_out;
   endfunction

   task automatic wait_mem_op(input int max, output int cyc);
      cyc = -1;
      for (int i = 1; i <= max; i++) begin
         tick;
         if (bus.rw_mem_op) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic wait_done(input int r, input int max, output int cyc);
      cyc = -1;
      for (int i = 1; i <= max; i++) begin
         tick;
         if (done_of(r)) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_mem_op"},  32'(bus.rw_mem_op), 32'(0));
      chk({tag, "_rw"},      32'(bus.rw_read_write), 32'(1));
      chk({tag, "_addr"},    32'(bus.rw_addr), 32'(0));
      chk({tag, "_din"},     32'(bus.rw_data_in), 32'(0));
      chk({tag, "_ready0"},  32'(bus.req0_ready), 32'(1));
      chk({tag, "_ready1"},  32'(bus.req1_ready), 32'(1));
      chk({tag, "_dout0"},   32'(bus.req0_data_out), 32'(0));
      chk({tag, "_dout1"},   32'(bus.req1_data_out), 32'(0));
      chk({tag, "_pulses"},  32'({bus.req0_done, bus.req1_done,
                                  bus.req0_data_ready, bus.req1_data_ready}), 32'(0));
      chk({tag, "_errs"},    32'({err_timeout, err_overrun}), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int got;
      int n0;
      logic granted1;
      logic seen;

      //             req rd    addr   wdata        rdata        lat done dout
      vecs[0] = '{0, 1'b0, 4'h4, 28'h6400000, 28'h0000000, 3, 4, 28'h0000000};
      vecs[1] = '{1, 1'b1, 4'h8, 28'h0000000, 28'h0ABCDEF, 3, 4, 28'h0ABCDEF};
      vecs[2] = '{0, 1'b1, 4'h8, 28'h0000055, 28'h1234567, 1, 2, 28'h1234567};
      vecs[3] = '{1, 1'b0, 4'h2, 28'hFFFFFFF, 28'h0000000, 0, 3, 28'h0ABCDEF};
      vecs[4] = '{0, 1'b0, 4'hF, 28'h0000001, 28'h0000000, 1, 3, 28'h1234567};
      vecs[5] = '{1, 1'b1, 4'h0, 28'h7777777, 28'h0000000, 5, 6, 28'h0000000};
      last_rd[0] = '0;
      last_rd[1] = '0;

      reset = 1'b1;
      drive_req(0, 0, 0, 0, 0);
      drive_req(1, 0, 0, 0, 0);
      bus.rw_ready = 1'b1;
      bus.rw_data_ready = 1'b0;
      bus.rw_data_out = '0;
      tick; tick; tick;
      check_reset_values("rst");
      reset = 1'b0;
      tick;

      // ---------------- table of single transactions ----------------
      for (int v = 0; v < 6; v++) begin
         drive_req(vecs[v].req, 1, vecs[v].rd, vecs[v].addr, vecs[v].wdata);
         tick;
         drive_req(vecs[v].req, 0, 0, 0, 0);
         chk("t_ready_low", 32'(rdy(vecs[v].req)), 32'(0));
         chk("t_op_early", 32'(bus.rw_mem_op), 32'(0));
         tick;
         chk("t_op_at_T2", 32'(bus.rw_mem_op), 32'(1));
         chk("t_rw", 32'(bus.rw_read_write), 32'(vecs[v].rd));
         chk("t_addr", 32'(bus.rw_addr), 32'(vecs[v].addr));
         chk("t_din", 32'(bus.rw_data_in), 32'(vecs[v].wdata));
         got = -1;
         for (int c = 0; c < 12; c++) begin
            if (vecs[v].rd) begin
               bus.rw_ready = 1'b0;
               bus.rw_data_ready = (c == vecs[v].lat);
               bus.rw_data_out = (c == vecs[v].lat) ? vecs[v].rdata : 28'h5A5A5A5;
            end else begin
               bus.rw_ready = (c >= vecs[v].lat);
               bus.rw_data_ready = (c == 1);
               bus.rw_data_out = 28'h3C3C3C3;
            end
            tick;
            if (c == 0) chk("t_op_one_cycle", 32'(bus.rw_mem_op), 32'(0));
            if (done_of(vecs[v].req)) begin
               got = c + 1;
               break;
            end
         end
         bus.rw_data_ready = 1'b0;
         bus.rw_ready = 1'b1;
         chk("t_done_cycle", got, vecs[v].exp_done);
         chk("t_data_ready", 32'(drdy_of(vecs[v].req)), 32'(vecs[v].rd));
         chk("t_ready_back", 32'(rdy(vecs[v].req)), 32'(1));
         chk("t_dout", 32'(dout_of(vecs[v].req)), 32'(vecs[v].exp_dout));
         chk("t_addr_held", 32'(bus.rw_addr), 32'(vecs[v].addr));
         chk("t_other_done", 32'(done_of(1 - vecs[v].req)), 32'(0));
         if (vecs[v].rd) last_rd[vecs[v].req] = vecs[v].rdata;
         tick;
         chk("t_done_pulse", 32'(done_of(vecs[v].req)), 32'(0));
         $display("txn %0d: req%0d %s addr=%0h done after %0d cycles",
                  v, vecs[v].req, vecs[v].rd ? "read" : "write", vecs[v].addr, got);
      end

      // ---------------- simultaneous strobes ----------------
      drive_req(0, 1, 1, REG_FIFO1, 28'h0);
      drive_req(1, 1, 0, 4'h2, 28'h0C0FFEE);
      tick;
      drive_req(0, 0, 0, 0, 0);
      drive_req(1, 0, 0, 0, 0);
      chk("sim_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'(0));
      wait_mem_op(4, cyc);
      chk("sim_first_lat", cyc, 1);
      chk("sim_first_addr", 32'(bus.rw_addr), 32'(8));
      chk("sim_first_rw", 32'(bus.rw_read_write), 32'(1));
      bus.rw_ready = 1'b0;
      tick;
      bus.rw_data_ready = 1'b1;
      bus.rw_data_out = 28'h0F0F0F0;
      bus.rw_ready = 1'b1;
      tick;
      bus.rw_data_ready = 1'b0;
      chk("sim_done0", 32'(bus.req0_done), 32'(1));
      chk("sim_dout0", 32'(bus.req0_data_out), 32'(28'h0F0F0F0));
      last_rd[0] = 28'h0F0F0F0;
      wait_mem_op(4, cyc);
      chk("sim_second_lat", cyc, 1);
      chk("sim_second_addr", 32'(bus.rw_addr), 32'(2));
      chk("sim_second_rw", 32'(bus.rw_read_write), 32'(0));
      chk("sim_second_din", 32'(bus.rw_data_in), 32'(28'h0C0FFEE));
      wait_done(1, 10, cyc);
      chk("sim_done1_lat", cyc, 3);
      chk("sim_ready1", 32'(bus.req1_ready), 32'(1));
      $display("txn sim: req0 read then req1 write issued in order");

      // ---------------- starvation guard ----------------
      drive_req(1, 1, 0, 4'h3, 28'h1111111);
      drive_req(0, 1, 1, REG_FIFO1, 28'h0);
      tick;
      drive_req(0, 0, 0, 0, 0);
      drive_req(1, 0, 0, 0, 0);
      n0 = 0;
      granted1 = 1'b0;
      for (int g = 0; g < 12; g++) begin
         wait_mem_op(6, cyc);
         if (cyc < 0) begin
            chk("starve_issue_timeout", cyc, 1);
            break;
         end
         if (bus.rw_addr == 4'h3) begin
            granted1 = 1'b1;
            break;
         end
         n0++;
         bus.rw_ready = 1'b0;
         tick;
         bus.rw_data_ready = 1'b1;
         bus.rw_data_out = 28'(n0);
         tick;
         bus.rw_data_ready = 1'b0;
         chk("starve_r0_done", 32'(bus.req0_done), 32'(1));
         last_rd[0] = 28'(n0);
         drive_req(0, 1, 1, REG_FIFO1, 28'h0);
         tick;
         drive_req(0, 0, 0, 0, 0);
         bus.rw_ready = 1'b1;
      end
      chk("starve_r0_grants", n0, 8);
      chk("starve_r1_granted", 32'(granted1), 32'(1));
      wait_done(1, 10, cyc);
      chk("starve_r1_done", cyc, 3);
      wait_mem_op(6, cyc);
      chk("starve_drain_lat", cyc, 1);
      bus.rw_ready = 1'b0;
      tick;
      bus.rw_data_ready = 1'b1;
      bus.rw_data_out = 28'h0000BAD;
      tick;
      bus.rw_data_ready = 1'b0;
      bus.rw_ready = 1'b1;
      chk("starve_drain_dout", 32'(bus.req0_data_out), 32'(28'h0000BAD));
      last_rd[0] = 28'h0000BAD;
      $display("txn starve: req1 granted after %0d req0 grants", n0);

      // ---------------- timeout ----------------
      chk("to_err_before", 32'(err_timeout), 32'(0));
      bus.rw_data_ready = 1'b1;       // stray pulse while idle
      bus.rw_data_out = 28'hBADBEEF;
      tick;
      bus.rw_data_ready = 1'b0;
      chk("to_stray_ignored", 32'(bus.req0_data_ready), 32'(0));
      drive_req(0, 1, 1, REG_FIFO1, 28'h0);
      tick;
      drive_req(0, 0, 0, 0, 0);
      wait_mem_op(4, cyc);
      bus.rw_ready = 1'b0;
      got = -1;
      seen = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         tick;
         if (bus.req0_data_ready) seen = 1'b1;
         if (bus.req0_done) begin
            got = i;
            break;
         end
      end
      chk("to_cycles", got, 256);
      chk("to_err", 32'(err_timeout), 32'(1));
      chk("to_no_data_ready", 32'(seen), 32'(0));
      chk("to_dout_kept", 32'(bus.req0_data_out), 32'(last_rd[0]));
      chk("to_ready", 32'(bus.req0_ready), 32'(1));
      bus.rw_ready = 1'b1;
      tick;
      chk("to_err_sticky", 32'(err_timeout), 32'(1));
      $display("txn timeout: req0 read aborted after %0d cycles", got);

      // ---------------- overrun and reset during WAIT ----------------
      chk("ovr_before", 32'(err_overrun), 32'(0));
      drive_req(0, 1, 0, REG_RESET, 28'h2222222);
      tick;
      drive_req(0, 1, 0, 4'h9, 28'h3333333);
      tick;
      drive_req(0, 0, 0, 0, 0);
      chk("ovr_flag", 32'(err_overrun), 32'(1));
      chk("ovr_issue", 32'(bus.rw_mem_op), 32'(1));
      chk("ovr_first_kept", 32'(bus.rw_addr), 32'(REG_RESET));
      bus.rw_ready = 1'b0;
      tick;
      tick;
      chk("ovr_sticky", 32'(err_overrun), 32'(1));
      reset = 1'b1;
      #1;
      check_reset_values("wrst");
      tick;
      reset = 1'b0;
      bus.rw_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (bus.req0_done || bus.req1_done || bus.rw_mem_op) seen = 1'b1;
      end
      chk("wrst_no_activity", 32'(seen), 32'(0));
      $display("txn overrun+reset: err_overrun set, transaction discarded by reset");

      // ---------------- reset during ISSUE ----------------
      drive_req(1, 1, 1, REG_FIFO1, 28'h0);
      tick;
      drive_req(1, 0, 0, 0, 0);
      tick;
      chk("irst_issue", 32'(bus.rw_mem_op), 32'(1));
      reset = 1'b1;
      #1;
      chk("irst_op_low", 32'(bus.rw_mem_op), 32'(0));
      chk("irst_ready1", 32'(bus.req1_ready), 32'(1));
      tick;
      reset = 1'b0;
      tick;
      chk("irst_no_done", 32'(bus.req1_done), 32'(0));
      $display("txn issue-reset: strobe withdrawn immediately");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tdc_rw_arbiter.md
# tdc_rw_arbiter

Two-requester arbiter for the single TDC-GPX read/write controller port. It lets the acquisition controller (requester 0) and the host register-access path (requester 1) share that port. Each requester gets a one-deep request slot and fixed priority to requester 0, with a starvation guard for requester 1. A completion timeout keeps a hung bus cycle from locking the port.

## Interface
Parameters:
- STARVE_LIMIT, 8: consecutive requester-0 grants allowed while requester 1 is pending.
- TIMEOUT_CYCLES, 255: cycles in WAIT before a transaction is aborted (8-bit counter).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- reqN_mem_op  in  1  (N=0,1) single-cycle request strobe; honoured only while reqN_ready=1.
- reqN_read_write  in  1  1=read, 0=write; sampled with the strobe.
- reqN_addr  in  4  TDC-GPX register address; sampled with the strobe.
- reqN_data_in  in  28  write data; sampled with the strobe.
- reqN_ready  out  1  slot empty and no transaction of N in flight.
- reqN_data_out  out  28  read result; held until the next read of N completes.
- reqN_data_ready  out  1  one-cycle pulse: read of N complete.
- reqN_done  out  1  one-cycle pulse: any transaction of N complete, including an aborted one.
- rw_ready  in  1  downstream controller idle.
- rw_data_out  in  28  downstream read data; valid with rw_data_ready.
- rw_data_ready  in  1  downstream read-complete pulse.
- rw_mem_op  out  1  one-cycle downstream strobe.
- rw_read_write, rw_addr, rw_data_in  out  1/4/28  downstream command, held stable from ISSUE until completion.
- err_timeout  out  1  sticky; set on abort, cleared by reset only.
- err_overrun  out  1  sticky; set when a strobe arrives while reqN_ready=0.

## Operation
- Slots: a strobe while ready captures {rw, addr, data} into slot N and clears reqN_ready on the next edge. A strobe while not ready is dropped and sets err_overrun.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE → ISSUE: taken when rw_ready=1 and any slot is full. The arbiter picks the grant, loads the rw_* command registers from the chosen slot, and frees that slot register.
- Grant rule: requester 0 wins unless slot 1 is full and starve_cnt ≥ STARVE_LIMIT. starve_cnt increments on each requester-0 grant while slot 1 is full, and clears on any requester-1 grant.
- ISSUE: rw_mem_op=1 for exactly one cycle, then WAIT. The timeout counter is cleared.
- WAIT, read: completes on rw_data_ready. rw_data_out is copied to reqG_data_out. reqG_data_ready and reqG_done pulse on the next cycle.
- WAIT, write: completes on the first cycle with rw_ready=1 at least 2 cycles after ISSUE. reqG_done then pulses.
- Completion returns the FSM to IDLE and reasserts reqG_ready in the same cycle as the done pulse.
- Timeout: when the counter reaches TIMEOUT_CYCLES in WAIT, the FSM returns to IDLE and sets err_timeout. reqG_done pulses; for a read, reqG_data_ready does not pulse and reqG_data_out keeps its old value.
- rw_data_ready outside WAIT, or during a write, is ignored.

## Timing
- Reset values: rw_mem_op=0, rw_read_write=1, rw_addr=0, rw_data_in=0, reqN_ready=1, reqN_data_out=0, reqN_data_ready=0, reqN_done=0, err_*=0. FSM in IDLE, starve_cnt=0, both slots empty.
- All outputs are registered.
- Best case: strobe at cycle T → rw_mem_op high at T+2, given rw_ready=1 and the other requester idle.
- Read return: rw_data_ready at cycle R → reqN_data_ready and reqN_ready high at R+1.
- Simultaneous strobes from both requesters: both are captured. Requester 0 is issued first; requester 1 is issued at the next IDLE with rw_ready=1.
- A strobe from the requester currently in flight is an overrun (ready is low).
- The other requester may fill its slot during WAIT. Back-to-back issue is one IDLE cycle after completion.
- Reset mid-transaction: the transaction is discarded with no done pulse, and rw_mem_op is forced low immediately.

## Structure
- Shared package tdc_gpx_pkg holds:
  - TDC_ADDR_W=4 and TDC_DATA_W=28.
  - Register index constants (REG_FIFO1=8, REG_RESET=4).
  - Arbiter state encoding: 2-bit IDLE=0, ISSUE=1, WAIT=2.
- Sub-module tdc_rw_req_slot, instantiated twice: the one-deep capture register, valid bit, ready and overrun-flag generation.

## Test plan
- Single write, requester 0: addr=4, data=28'h6400000 → rw_mem_op at T+2 with those values; req0_done pulses once rw_ready returns; req0_ready is back high.
- Single read, requester 1: addr=8; downstream returns 28'h0ABCDEF → req1_data_out=28'h0ABCDEF and req1_data_ready pulses one cycle after rw_data_ready.
- Simultaneous strobes: req0 reads addr 8, req1 writes addr 2 → req0 is issued first and req1 second, with no lost command.
- Starvation guard: requester 0 keeps re-requesting and req1 stays pending → req1 is granted after exactly 8 requester-0 grants.
- Timeout: a read where rw_data_ready never arrives → after 255 WAIT cycles the FSM is in IDLE, err_timeout=1, req0_done pulses, req0_data_ready stays 0.
- Overrun and reset: a second req0 strobe while in flight sets err_overrun=1. Asserting reset during WAIT gives all reset values with no done pulse.
